// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the run monitor: FSM encoding, opcode width
// and the default halt opcode.
package run_monitor_pkg;

  localparam int OPC_W = 6;
  localparam logic [OPC_W-1:0] HALT_OPC_DEFAULT = 6'b010001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TMO  = 2'd3
  } state_t;

endpackage

// File: rtl/run_monitor_chan.sv
// One monitored channel: sticky halt flag, saturating retire counter and,
// when RUN_MONITOR_STALL_EN is defined, an idle counter driving a sticky stall flag.
module run_monitor_chan
  import run_monitor_pkg::*;
#(
  parameter int               CNT_W     = 32,
  parameter int               STALL_LIM = 64,
  parameter logic [OPC_W-1:0] HALT_OPC  = HALT_OPC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic             valid,
  input  logic [OPC_W-1:0] opc,
  output logic             halted,
  output logic             halted_next,
  output logic             stall,
  output logic [CNT_W-1:0] retired
);

  logic accept;

  if (STALL_LIM < 1) begin : g_bad_stall_lim
    $error("run_monitor_chan: STALL_LIM must be at least 1");
  end

  // A halted channel stops listening; the halt instruction itself still retires.
  assign accept      = run & valid & ~halted;
  assign halted_next = halted | (accept & (opc == HALT_OPC));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted  <= 1'b0;
      retired <= '0;
    end else if (clear) begin
      halted  <= 1'b0;
      retired <= '0;
    end else if (accept) begin
      halted <= halted_next;
      if (~&retired) retired <= retired + 1'b1;
    end
  end

`ifdef RUN_MONITOR_STALL_EN
  localparam int IDLE_W = $clog2(STALL_LIM + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // Idle count saturates at the limit so the flag cannot be lost to wrap-around.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      stall    <= 1'b0;
    end else if (clear) begin
      idle_cnt <= '0;
      stall    <= 1'b0;
    end else if (valid) begin
      idle_cnt <= '0;
    end else if (run && !halted && idle_cnt != IDLE_W'(STALL_LIM)) begin
      idle_cnt <= idle_cnt + 1'b1;
      if (idle_cnt == IDLE_W'(STALL_LIM - 1)) stall <= 1'b1;
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: rtl/run_monitor.sv
// Run monitor top: IDLE/RUN/DONE/TMO controller with cycle counter over NUM_CH
// channels. Optional stall detection is enabled by defining RUN_MONITOR_STALL_EN.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int               NUM_CH    = 2,
  parameter int               INST_W    = 32,
  parameter logic [OPC_W-1:0] HALT_OPC  = HALT_OPC_DEFAULT,
  parameter int               CNT_W     = 32,
  parameter int               TIMEOUT   = 1000000,
  parameter int               STALL_LIM = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_CH-1:0]         inst_valid,
  input  logic [NUM_CH*INST_W-1:0]  inst,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout,
  output logic [NUM_CH-1:0]         halted,
  output logic [NUM_CH-1:0]         stall,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [NUM_CH*CNT_W-1:0]   retired_cnt
);

  state_t            state, state_nxt;
  logic              run, clear, tmo_hit;
  logic [NUM_CH-1:0] halted_nxt;
  logic              unused_operand_bits;

  assign run     = (state == RUN);
  assign clear   = start & ~run;
  assign tmo_hit = run && (cycle_cnt == CNT_W'(TIMEOUT - 1));

  // Only the opcode field is inspected; operand bits are deliberately unused.
  assign unused_operand_bits = ^inst;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, TMO: if (start) state_nxt = RUN;
      RUN: begin
        if (&halted_nxt)  state_nxt = DONE;
        else if (tmo_hit) state_nxt = TMO;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Counter freezes at TIMEOUT-1 so it reads the last RUN cycle after a timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 cycle_cnt <= '0;
    else if (clear)                             cycle_cnt <= '0;
    else if (run && !tmo_hit && ~&cycle_cnt)    cycle_cnt <= cycle_cnt + 1'b1;
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign timeout = (state == TMO);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    run_monitor_chan #(
      .CNT_W     (CNT_W),
      .STALL_LIM (STALL_LIM),
      .HALT_OPC  (HALT_OPC)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .run         (run),
      .valid       (inst_valid[i]),
      .opc         (inst[i*INST_W + INST_W - 1 -: OPC_W]),
      .halted      (halted[i]),
      .halted_next (halted_nxt[i]),
      .stall       (stall[i]),
      .retired     (retired_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_run_monitor.sv
// Directed and randomized checks of run_monitor against a cycle-level reference model.
module tb_run_monitor;

  localparam int TIMEOUT   = 20;
  localparam int STALL_LIM = 4;
  localparam logic [31:0] HALT_W = 32'h4400_0000;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_TMO = 3;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  inst_valid;
  logic [63:0] inst;
  logic        busy, done, timeout;
  logic [1:0]  halted, stall;
  logic [31:0] cycle_cnt;
  logic [63:0] retired_cnt;

  int nerr = 0;
  int nchk = 0;

  int          m_st;
  logic [31:0] m_cyc;
  logic [31:0] m_ret [2];
  bit          m_h [2];
  int          m_idle [2];
  bit          m_stall [2];

  run_monitor #(
    .NUM_CH(2), .INST_W(32), .HALT_OPC(6'b010001), .CNT_W(32),
    .TIMEOUT(TIMEOUT), .STALL_LIM(STALL_LIM)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .inst_valid(inst_valid), .inst(inst),
    .busy(busy), .done(done), .timeout(timeout), .halted(halted), .stall(stall),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = M_IDLE;
    m_cyc = '0;
    for (int c = 0; c < 2; c++) begin
      m_ret[c] = '0; m_h[c] = 0; m_idle[c] = 0; m_stall[c] = 0;
    end
  endtask

  // Applies one rising edge of behaviour to the model from the spec's rules.
  task automatic model_step();
    logic [31:0] w;
    bit tmo;
    if (m_st != M_RUN) begin
      if (start) begin
        model_reset();
        m_st = M_RUN;
      end
    end else begin
      tmo = (m_cyc == 32'(TIMEOUT - 1));
      for (int c = 0; c < 2; c++) begin
        w = inst[c*32 +: 32];
        if (inst_valid[c]) m_idle[c] = 0;
        else if (!m_h[c]) begin
          if (m_idle[c] < STALL_LIM) m_idle[c]++;
          if (m_idle[c] == STALL_LIM) m_stall[c] = 1;
        end
        if (inst_valid[c] && !m_h[c]) begin
          if (m_ret[c] != 32'hFFFF_FFFF) m_ret[c]++;
          if (w[31:26] == 6'b010001) m_h[c] = 1;
        end
      end
      if (m_h[0] && m_h[1]) m_st = M_DONE;
      else if (tmo)         m_st = M_TMO;
      if (!tmo && m_cyc != 32'hFFFF_FFFF) m_cyc++;
    end
  endtask

  function automatic logic [1:0] exp_stall();
`ifdef RUN_MONITOR_STALL_EN
    return {m_stall[1], m_stall[0]};
`else
    return 2'b00;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".busy"},    busy,        64'(m_st == M_RUN));
    chk({tag, ".done"},    done,        64'(m_st == M_DONE));
    chk({tag, ".timeout"}, timeout,     64'(m_st == M_TMO));
    chk({tag, ".halted"},  halted,      64'({m_h[1], m_h[0]}));
    chk({tag, ".stall"},   stall,       64'(exp_stall()));
    chk({tag, ".cycle"},   cycle_cnt,   64'(m_cyc));
    chk({tag, ".retired"}, retired_cnt, {m_ret[1], m_ret[0]});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) model_step();
    else       model_reset();
    #1;
    check_all(tag);
  endtask

  task automatic set_ch(input int c, input logic v, input logic [31:0] w);
    inst_valid[c]    = v;
    inst[c*32 +: 32] = w;
  endtask

  task automatic quiet();
    start = 1'b0; inst_valid = '0; inst = '0;
  endtask

  task automatic do_start(input string tag);
    quiet();
    start = 1'b1;
    tick(tag);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    quiet();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy, 0);       chk("rst.done", done, 0);
    chk("rst.timeout", timeout, 0); chk("rst.halted", halted, 0);
    chk("rst.stall", stall, 0);     chk("rst.cycle", cycle_cnt, 0);
    chk("rst.retired", retired_cnt, 0);
    reset = 1'b1;

    // inst_valid while idle is ignored
    set_ch(0, 1, NOP_W); set_ch(1, 1, HALT_W);
    repeat (2) tick("idle_ign");
    chk("idle_ign.busy", busy, 0);
    chk("idle_ign.retired", retired_cnt, 0);

    // basic halt: ch0 5 + halt, ch1 3 + halt (then ignored)
    do_start("basic_start");
    for (int c = 1; c <= 6; c++) begin
      set_ch(0, 1, (c == 6) ? HALT_W : NOP_W);
      set_ch(1, 1, (c == 4) ? HALT_W : NOP_W);
      tick("basic");
      if (c == 5) chk("basic.not_done_yet", done, 0);
    end
    chk("basic.done", done, 1);
    chk("basic.retired", retired_cnt, {32'd4, 32'd6});
    chk("basic.halted", halted, 2'b11);
    set_ch(0, 1, NOP_W); set_ch(1, 1, NOP_W);
    repeat (2) tick("done_hold");
    chk("done_hold.retired", retired_cnt, {32'd4, 32'd6});

    // start while busy is ignored
    do_start("busy_start");
    set_ch(0, 1, NOP_W);
    tick("busy_run");
    quiet(); start = 1'b1;
    tick("busy_restart");
    start = 1'b0;
    chk("busy_restart.cycle", cycle_cnt, 2);
    chk("busy_restart.ret0", retired_cnt[31:0], 1);
    chk("busy_restart.busy", busy, 1);

    // simultaneous halt
    set_ch(0, 1, HALT_W); set_ch(1, 1, HALT_W);
    tick("simul");
    chk("simul.done", done, 1);
    chk("simul.busy", busy, 0);
    chk("simul.retired", retired_cnt, {32'd1, 32'd2});

    // stall detection on ch0
    do_start("stall_start");
    for (int c = 1; c <= 4; c++) begin
      set_ch(0, 0, NOP_W); set_ch(1, 1, NOP_W);
      tick("stall");
      if (c == 3) chk("stall.before_lim", stall, 0);
    end
`ifdef RUN_MONITOR_STALL_EN
    chk("stall.flag", stall, 2'b01);
`else
    chk("stall.flag", stall, 2'b00);
`endif
    chk("stall.busy", busy, 1);
    set_ch(0, 1, HALT_W); set_ch(1, 1, HALT_W);
    tick("stall_end");

    // timeout: ch1 never halts
    do_start("tmo_start");
    for (int c = 1; c <= TIMEOUT; c++) begin
      set_ch(0, c == 1, HALT_W);
      set_ch(1, 1'($urandom_range(0, 1)), NOP_W);
      tick("tmo");
      if (c == TIMEOUT - 1) begin
        chk("tmo.pre_busy", busy, 1);
        chk("tmo.pre_cycle", cycle_cnt, 19);
      end
    end
    chk("tmo.timeout", timeout, 1);
    chk("tmo.busy", busy, 0);
    chk("tmo.cycle", cycle_cnt, 19);
    chk("tmo.halted", halted, 2'b01);
    set_ch(1, 1, HALT_W);
    repeat (3) tick("tmo_hold");
    chk("tmo_hold.timeout", timeout, 1);
    chk("tmo_hold.cycle", cycle_cnt, 19);

    // last halt coincides with the timeout edge: DONE wins
    do_start("prio_start");
    for (int c = 1; c <= TIMEOUT; c++) begin
      set_ch(0, c == 1, HALT_W);
      set_ch(1, 1, (c == TIMEOUT) ? HALT_W : NOP_W);
      tick("prio");
    end
    chk("prio.done", done, 1);
    chk("prio.timeout", timeout, 0);

    // mid-run reset
    do_start("mrst_start");
    for (int c = 1; c <= 7; c++) begin
      set_ch(0, 1'($urandom_range(0, 1)), NOP_W);
      set_ch(1, 1'($urandom_range(0, 1)), NOP_W);
      tick("mrst_run");
    end
    reset = 1'b0;
    #1;
    model_reset();
    chk("mrst.busy", busy, 0);     chk("mrst.cycle", cycle_cnt, 0);
    chk("mrst.retired", retired_cnt, 0);
    chk("mrst.halted", halted, 0); chk("mrst.stall", stall, 0);
    repeat (2) tick("mrst_hold");
    reset = 1'b1;
    quiet();
    repeat (3) tick("mrst_wait");
    chk("mrst_wait.busy", busy, 0);
    do_start("mrst_restart");
    set_ch(0, 1, NOP_W);
    tick("mrst_new");
    chk("mrst_new.cycle", cycle_cnt, 1);
    chk("mrst_new.retired", retired_cnt, 64'd1);
    set_ch(0, 1, HALT_W); set_ch(1, 1, HALT_W);
    tick("mrst_end");

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      do_start("rnd_start");
      for (int k = 0; k < 25; k++) begin
        for (int c = 0; c < 2; c++)
          set_ch(c, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0) ? HALT_W : 32'($urandom));
        start = ($urandom_range(0, 15) == 0);
        tick("rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
